// File: rtl/tb_assert_pkg.sv
// Shared types and defaults for the assertion run controller.
package tb_assert_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int CW_DEF      = 16;
  localparam int TIMEOUT_DEF = 100000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tb_rr_arbiter.sv
// Round-robin one-hot grant across requesters; the search starts at the pointer,
// which moves just past each granted requester.
module tb_rr_arbiter
  import tb_assert_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gidx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   pos;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (!found && en && valid[pos[IW-1:0]]) begin
        grant[pos[IW-1:0]] = 1'b1;
        gidx               = pos[IW-1:0];
        found              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/tb_assert_ctrl.sv
// Run controller for assertion events: arbitrates requesters, counts pass/fail,
// and ends a run on finish/drain, first fail (optional) or watchdog timeout.
module tb_assert_ctrl
  import tb_assert_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int CW          = CW_DEF,
  parameter  int TIMEOUT     = TIMEOUT_DEF,
  parameter  int DIE_ON_FAIL = 0,
  localparam int GW          = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            finish_req,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_pass,
  output logic [NREQ-1:0] req_ready,
  output logic            busy,
  output logic            done,
  output logic            success,
  output logic            died,
  output logic            timed_out,
  output logic [CW-1:0]   pass_cnt,
  output logic [CW-1:0]   fail_cnt,
  output logic [CW-1:0]   tot_cnt,
  output logic [GW-1:0]   grant_id
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t          state;
  logic [31:0]     wd;
  logic [31:0]     wd_inc;
  logic            active;
  logic [NREQ-1:0] grant;
  logic [GW-1:0]   gidx;
  logic            acc, acc_pass;
  logic [CW-1:0]   pass_n, fail_n, tot_n;
  logic            to_hit, die_hit, empty_hit, fin;

  assign active = (state == RUN) || (state == DRAIN);

  tb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (active),
    .valid (req_valid),
    .grant (grant),
    .gidx  (gidx)
  );

  assign req_ready = grant;
  assign acc       = |grant;
  assign acc_pass  = |(grant & req_pass);

  assign pass_n = (acc && acc_pass)  ? sat_inc(pass_cnt) : pass_cnt;
  assign fail_n = (acc && !acc_pass) ? sat_inc(fail_cnt) : fail_cnt;
  assign tot_n  = acc ? sat_inc(tot_cnt) : tot_cnt;

  // End-of-run causes, highest priority first; finish_req is handled last.
  assign wd_inc    = wd + 32'd1;
  assign to_hit    = (TIMEOUT != 0) && (wd_inc == 32'(TIMEOUT));
  assign die_hit   = (DIE_ON_FAIL != 0) && acc && !acc_pass;
  assign empty_hit = (state == DRAIN) && (req_valid == '0);
  assign fin       = to_hit || die_hit || empty_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      tot_cnt   <= '0;
      wd        <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      success   <= 1'b0;
      died      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            tot_cnt   <= '0;
            wd        <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            success   <= 1'b0;
            died      <= 1'b0;
            timed_out <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          pass_cnt <= pass_n;
          fail_cnt <= fail_n;
          tot_cnt  <= tot_n;
          wd       <= wd_inc;
          if (acc) grant_id <= gidx;
          if (fin) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= to_hit;
            died      <= !to_hit && die_hit;
            success   <= (fail_n == '0) && (tot_n != '0) && !to_hit && !die_hit;
          end else if ((state == RUN) && finish_req) begin
            state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_assert_ctrl.sv
// Directed bench for tb_assert_ctrl: default, die/timeout and narrow-counter instances.
module tb_tb_assert_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, finish_req;
  logic [3:0] req_valid, req_pass;

  logic [3:0]  a_ready, b_ready, c_ready;
  logic        a_busy, a_done, a_succ, a_died, a_to;
  logic        b_busy, b_done, b_succ, b_died, b_to;
  logic        c_busy, c_done, c_succ, c_died, c_to;
  logic [15:0] a_pass, a_fail, a_tot, b_pass, b_fail, b_tot;
  logic [3:0]  c_pass, c_fail, c_tot;
  logic [1:0]  a_gid, b_gid, c_gid;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tb_assert_ctrl #(.NREQ(4), .CW(16), .TIMEOUT(100000), .DIE_ON_FAIL(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .finish_req(finish_req),
    .req_valid(req_valid), .req_pass(req_pass), .req_ready(a_ready),
    .busy(a_busy), .done(a_done), .success(a_succ), .died(a_died), .timed_out(a_to),
    .pass_cnt(a_pass), .fail_cnt(a_fail), .tot_cnt(a_tot), .grant_id(a_gid)
  );

  tb_assert_ctrl #(.NREQ(4), .CW(16), .TIMEOUT(10), .DIE_ON_FAIL(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .finish_req(finish_req),
    .req_valid(req_valid), .req_pass(req_pass), .req_ready(b_ready),
    .busy(b_busy), .done(b_done), .success(b_succ), .died(b_died), .timed_out(b_to),
    .pass_cnt(b_pass), .fail_cnt(b_fail), .tot_cnt(b_tot), .grant_id(b_gid)
  );

  tb_assert_ctrl #(.NREQ(4), .CW(4), .TIMEOUT(100000), .DIE_ON_FAIL(0)) u_c (
    .clk(clk), .rst(rst), .start(start), .finish_req(finish_req),
    .req_valid(req_valid), .req_pass(req_pass), .req_ready(c_ready),
    .busy(c_busy), .done(c_done), .success(c_succ), .died(c_died), .timed_out(c_to),
    .pass_cnt(c_pass), .fail_cnt(c_fail), .tot_cnt(c_tot), .grant_id(c_gid)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] p;
    logic [3:0] r;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_all();
    req_valid  = 4'b0000;
    finish_req = 1'b1;
    tick();
    finish_req = 1'b0;
    tick();
  endtask

  initial begin
    int first_done;

    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1111, 4'b1000};
    tbl[8]  = '{4'b1010, 4'b0000, 4'b0010};
    tbl[9]  = '{4'b0011, 4'b0001, 4'b0001};
    tbl[10] = '{4'b1001, 4'b1000, 4'b1000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0110, 4'b0100, 4'b0010};
    tbl[13] = '{4'b0110, 4'b0100, 4'b0100};

    rst = 1'b1; start = 1'b0; finish_req = 1'b0;
    req_valid = 4'b0000; req_pass = 4'b0000;
    #3;
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_busy",  32'(a_busy), 0);
    chk("rst_done",  32'(a_done), 0);
    chk("rst_succ",  32'(a_succ), 0);
    chk("rst_tot",   32'(a_tot), 0);
    chk("rst_gid",   32'(a_gid), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("idle_ready", 32'(a_ready), 0);
    req_valid = 4'b0000;

    // Round-robin and mixed pass/fail table
    do_start();
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].v;
      req_pass  = tbl[i].p;
      #1;
      chk($sformatf("rr_vec%0d", i), 32'(a_ready), 32'(tbl[i].r));
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("tbl_tot",  32'(a_tot), 13);
    chk("tbl_pass", 32'(a_pass), 11);
    chk("tbl_fail", 32'(a_fail), 2);
    chk("tbl_gid",  32'(a_gid), 2);
    finish_all();
    chk("tbl_done", 32'(a_done), 1);
    chk("tbl_succ", 32'(a_succ), 0);
    chk("tbl_busy", 32'(a_busy), 0);

    // Three passes from requester 0
    do_start();
    chk("p3_busy", 32'(a_busy), 1);
    chk("p3_clr",  32'(a_tot), 0);
    req_valid = 4'b0001; req_pass = 4'b0001;
    #1;
    chk("p3_ready", 32'(a_ready), 32'(4'b0001));
    tick();
    chk("p3_tot1", 32'(a_tot), 1);
    tick();
    tick();
    finish_all();
    chk("p3_done", 32'(a_done), 1);
    chk("p3_pass", 32'(a_pass), 3);
    chk("p3_fail", 32'(a_fail), 0);
    chk("p3_tot",  32'(a_tot), 3);
    chk("p3_succ", 32'(a_succ), 1);
    chk("p3_died", 32'(a_died), 0);
    chk("p3_to",   32'(a_to), 0);
    chk("p3_gid",  32'(a_gid), 0);
    req_valid = 4'b1111; finish_req = 1'b1;
    #1;
    chk("done_ready", 32'(a_ready), 0);
    tick();
    tick();
    finish_req = 1'b0;
    chk("done_hold_tot",  32'(a_tot), 3);
    chk("done_hold_succ", 32'(a_succ), 1);
    req_valid = 4'b0000;

    // finish_req while requester 1 still has events queued
    do_start();
    req_valid = 4'b0010; req_pass = 4'b0010; finish_req = 1'b1;
    tick();
    finish_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain_ready%0d", i), 32'(a_ready), 32'(4'b0010));
      chk($sformatf("drain_busy%0d", i), 32'(a_busy), 1);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    chk("drain_done", 32'(a_done), 1);
    chk("drain_tot",  32'(a_tot), 4);
    chk("drain_succ", 32'(a_succ), 1);
    chk("drain_gid",  32'(a_gid), 1);

    // Empty run
    do_start();
    finish_req = 1'b1;
    tick();
    finish_req = 1'b0;
    tick();
    chk("empty_done", 32'(a_done), 1);
    chk("empty_succ", 32'(a_succ), 0);
    chk("empty_tot",  32'(a_tot), 0);

    // Die on first fail from requester 2
    do_start();
    req_valid = 4'b0100; req_pass = 4'b0000;
    #1;
    chk("die_ready", 32'(b_ready), 32'(4'b0100));
    tick();
    chk("die_done", 32'(b_done), 1);
    chk("die_died", 32'(b_died), 1);
    chk("die_fail", 32'(b_fail), 1);
    chk("die_succ", 32'(b_succ), 0);
    chk("die_to",   32'(b_to), 0);
    finish_all();

    // Watchdog with TIMEOUT=10
    do_start();
    first_done = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (b_done && first_done == 0) first_done = k;
    end
    chk("to_cycles", 32'(first_done), 10);
    chk("to_flag",   32'(b_to), 1);
    chk("to_succ",   32'(b_succ), 0);
    chk("to_died",   32'(b_died), 0);
    finish_all();

    // 4-bit counters: saturation, then fails still counted
    do_start();
    req_valid = 4'b0001; req_pass = 4'b0001;
    repeat (20) tick();
    chk("sat_pass", 32'(c_pass), 15);
    chk("sat_tot",  32'(c_tot), 15);
    req_pass = 4'b0000;
    tick();
    tick();
    chk("sat_fail",  32'(c_fail), 2);
    chk("sat_tot2",  32'(c_tot), 15);
    chk("sat_pass2", 32'(c_pass), 15);
    finish_all();
    chk("sat_done", 32'(c_done), 1);
    chk("sat_succ", 32'(c_succ), 0);

    // Asynchronous reset in the middle of a run
    do_start();
    req_valid = 4'b1111; req_pass = 4'b1111;
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(a_ready), 0);
    chk("mrst_busy",  32'(a_busy), 0);
    chk("mrst_done",  32'(a_done), 0);
    chk("mrst_tot",   32'(a_tot), 0);
    chk("mrst_pass",  32'(a_pass), 0);
    chk("mrst_gid",   32'(a_gid), 0);
    #2;
    rst = 1'b0;
    tick();
    #1;
    chk("mrst_idle_ready", 32'(a_ready), 0);
    chk("mrst_idle_busy",  32'(a_busy), 0);
    do_start();
    #1;
    chk("mrst_ptr0", 32'(a_ready), 32'(4'b0001));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
